// File: rtl/drive_frame_sequencer_pkg.sv
// drive_frame_sequencer_pkg: OI drive opcode, radius constants, motion type codes, FSM states
package drive_frame_sequencer_pkg;
  localparam logic [7:0] OI_DRIVE = 8'd137;
  localparam logic [15:0] RAD_STRAIGHT = 16'h8000;
  localparam logic [15:0] RAD_LEFT = 16'h0001;
  localparam logic [15:0] RAD_RIGHT = 16'hFFFF;
  localparam logic [1:0] T_STOP = 2'b00;
  localparam logic [1:0] T_FWD = 2'b01;
  localparam logic [1:0] T_LEFT = 2'b10;
  localparam logic [1:0] T_RIGHT = 2'b11;
  localparam logic [31:0] STOP_FRAME = {16'h0000, RAD_STRAIGHT};
  typedef enum logic [2:0] {IDLE, SEND, RUN, SEND_STOP, DONE} state_t;
  function automatic logic [15:0] radius(input logic [1:0] t);
    return t == T_LEFT ? RAD_LEFT : t == T_RIGHT ? RAD_RIGHT : RAD_STRAIGHT;
  endfunction
endpackage

// File: rtl/drive_frame_sequencer_tick.sv
// motion_tick_gen: tick divider + duration counter; ports clk, rst(active-low), clear, load, duration[7:0] -> expired
module motion_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] duration,
  output logic       expired
);
  localparam int DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  logic [DW-1:0] div;
  logic [7:0] ticks, dur;
  assign expired = !clear && div == DIV_MAX && ticks == dur - 8'd1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= '0;
      ticks <= '0;
      dur <= '0;
    end else begin
      if (load) dur <= duration;
      if (clear) begin
        div <= '0;
        ticks <= '0;
      end else if (div == DIV_MAX) begin
        div <= '0;
        ticks <= ticks + 8'd1;
      end else div <= div + 1'b1;
    end
  end
endmodule

// File: rtl/drive_frame_sequencer.sv
// drive_frame_sequencer: turns motion commands into OI drive frames for a UART; ports clk, rst(active-low), motion_command/motion_speed/cmd_strobe in, tx_data/tx_valid/tx_ready handshake, busy, motion_done
module drive_frame_sequencer
  import drive_frame_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int SPEED_STEP = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] motion_command,
  input  logic [2:0] motion_speed,
  input  logic       cmd_strobe,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       motion_done
);
  state_t state, start_state;
  logic [31:0] frame, src_frame;
  logic [2:0] idx;
  logic pend, src_stop, frame_end, start, expired;
  logic [9:0] pend_cmd, src_cmd;
  logic [2:0] pend_spd, src_spd;
  logic [15:0] vel;
  always_comb begin
    src_cmd = cmd_strobe ? motion_command : pend_cmd;
    src_spd = cmd_strobe ? motion_speed : pend_spd;
    src_stop = src_cmd[9:8] == T_STOP || src_cmd[7:0] == 8'd0;
    vel = 16'(src_spd) * 16'(SPEED_STEP);
    src_frame = src_stop ? STOP_FRAME : {vel, radius(src_cmd[9:8])};
    start_state = src_stop ? SEND_STOP : SEND;
    frame_end = (state == SEND || state == SEND_STOP) && tx_ready && idx == 3'd4;
    start = ((cmd_strobe || pend) && (state == IDLE || frame_end)) || (state == RUN && cmd_strobe);
  end
  motion_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .clear(state != RUN),
    .load(start),
    .duration(src_cmd[7:0]),
    .expired(expired)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tx_valid <= 1'b0;
      tx_data <= '0;
      busy <= 1'b0;
      motion_done <= 1'b0;
      pend <= 1'b0;
      pend_cmd <= '0;
      pend_spd <= '0;
      frame <= '0;
      idx <= '0;
    end else begin
      motion_done <= 1'b0;
      if (cmd_strobe && (state == SEND || state == SEND_STOP || state == DONE)) begin
        pend <= 1'b1;
        pend_cmd <= motion_command;
        pend_spd <= motion_speed;
      end
      case (state)
        SEND, SEND_STOP: if (tx_ready) begin
          if (idx == 3'd4) begin
            tx_valid <= 1'b0;
            idx <= '0;
            state <= state == SEND ? RUN : DONE;
            motion_done <= state == SEND_STOP;
          end else begin
            idx <= idx + 3'd1;
            tx_data <= frame[31:24];
            frame <= {frame[23:0], 8'h00};
          end
        end
        RUN: if (expired) begin
          state <= SEND_STOP;
          frame <= STOP_FRAME;
          tx_data <= OI_DRIVE;
          tx_valid <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: ;
      endcase
      // a new or pending command overrides whatever the current state chose
      if (start) begin
        state <= start_state;
        frame <= src_frame;
        tx_data <= OI_DRIVE;
        tx_valid <= 1'b1;
        idx <= '0;
        busy <= 1'b1;
        pend <= 1'b0;
        motion_done <= 1'b0;
      end
    end
  end
endmodule
